// File: rtl/llsc_ctrl.sv
// -----------------------------------------------------------------------------
// llsc_ctrl -- load-linked / store-conditional request controller
//
// Sits between the CPU data port and the data cache. It sequences plain loads
// and stores and the LL/SC pair, drives a separate link module (which holds the
// reservation address and valid bit), and forwards bus snoop invalidates to
// that link module.
//
// Build option:
//   LLSC_SNOOP_EN  defined   : the snoop path is present. ccinv/ccsnoopaddr
//                              are registered onto invalid_bus/addr_bus, and a
//                              snoop hitting the reservation during the SC
//                              check cycle kills the SC.
//                  undefined : single-core build. The snoop inputs are
//                              ignored, addr_bus/invalid_bus are tied low, and
//                              an SC fails only when write_valid is low.
//
// Ports:
//   CLK          in   system clock, rising edge
//   nRST         in   asynchronous active-low reset
//   dmemREN      in   CPU load request, held until done
//   dmemWEN      in   CPU store request, held until done
//   datomic      in   request is LL (with REN) or SC (with WEN)
//   dmemaddr     in   CPU request address
//   c_ren        out  cache read request
//   c_wen        out  cache write request
//   c_addr       out  cache request address
//   c_ack        in   cache completion pulse
//   ccinv        in   snoop invalidate pulse
//   ccsnoopaddr  in   snoop address, valid with ccinv
//   addr_cpu     out  CPU-side address to the link module
//   addr_bus     out  snoop address to the link module
//   update       out  set-link pulse (LL completion)
//   invalid_cpu  out  local-store invalidate pulse (store completion)
//   invalid_bus  out  snoop invalidate pulse
//   write_valid  in   link valid and matching addr_cpu (combinational)
//   done         out  request completion pulse
//   sc_result    out  SC outcome, valid with done, 0 otherwise
// -----------------------------------------------------------------------------
module llsc_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic              datomic,
    input  logic [ADDR_W-1:0] dmemaddr,
    output logic              c_ren,
    output logic              c_wen,
    output logic [ADDR_W-1:0] c_addr,
    input  logic              c_ack,
    input  logic              ccinv,
    input  logic [ADDR_W-1:0] ccsnoopaddr,
    output logic [ADDR_W-1:0] addr_cpu,
    output logic [ADDR_W-1:0] addr_bus,
    output logic              update,
    output logic              invalid_cpu,
    output logic              invalid_bus,
    input  logic              write_valid,
    output logic              done,
    output logic              sc_result
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        SC_CHK  = 3'd2,
        WR      = 3'd3,
        SC_FAIL = 3'd4
    } state_t;

    state_t              state_r;
    state_t              next_state_s;

    logic                c_ren_r;
    logic                c_wen_r;
    logic [ADDR_W-1:0]   c_addr_r;
    logic [ADDR_W-1:0]   addr_cpu_r;
    logic                atomic_r;
    logic                update_r;
    logic                invalid_cpu_r;
    logic                done_r;
    logic                sc_result_r;

    logic                latch_s;
    logic                done_s;
    logic                update_s;
    logic                invalid_cpu_s;
    logic                sc_result_s;
    logic                kill_s;

    logic [ADDR_W-1:0]   addr_bus_r;
    logic                invalid_bus_r;

`ifdef LLSC_SNOOP_EN
    // Snoop forwarding register: runs regardless of the FSM so back-to-back
    // snoops produce back-to-back invalidate pulses.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            invalid_bus_r <= 1'b0;
            addr_bus_r    <= {ADDR_W{1'b0}};
        end else begin
            invalid_bus_r <= ccinv;
            if (ccinv) begin
                addr_bus_r <= ccsnoopaddr;
            end
        end
    end

    // SC kill: a snoop arriving now, or the one being forwarded now, that hits
    // the reservation address. The link module may not have seen either yet, so
    // write_valid alone cannot be trusted in this cycle.
    always_comb begin
        kill_s = 1'b0;
        if ((ccinv && (ccsnoopaddr == addr_cpu_r)) ||
            (invalid_bus_r && (addr_bus_r == addr_cpu_r))) begin
            kill_s = 1'b1;
        end else begin
            kill_s = 1'b0;
        end
    end
`else
    logic snoop_unused_s;

    // Single-core build: no snoop traffic reaches the link module.
    always_comb begin
        invalid_bus_r  = 1'b0;
        addr_bus_r     = {ADDR_W{1'b0}};
        kill_s         = 1'b0;
        snoop_unused_s = ccinv ^ (^ccsnoopaddr);
    end
`endif

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        next_state_s  = state_r;
        latch_s       = 1'b0;
        done_s        = 1'b0;
        update_s      = 1'b0;
        invalid_cpu_s = 1'b0;
        sc_result_s   = 1'b0;
        case (state_r)
            IDLE: begin
                // The CPU still holds its request while done is high; refusing
                // to accept in that cycle stops a completed request from being
                // replayed.
                if (!done_r && dmemREN) begin
                    next_state_s = RD;
                    latch_s      = 1'b1;
                end else if (!done_r && dmemWEN) begin
                    next_state_s = datomic ? SC_CHK : WR;
                    latch_s      = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RD: begin
                if (c_ack) begin
                    next_state_s = IDLE;
                    done_s       = 1'b1;
                    update_s     = atomic_r;
                end else begin
                    next_state_s = RD;
                end
            end
            SC_CHK: begin
                if (write_valid && !kill_s) begin
                    next_state_s = WR;
                end else begin
                    next_state_s = SC_FAIL;
                    done_s       = 1'b1;
                end
            end
            WR: begin
                if (c_ack) begin
                    next_state_s  = IDLE;
                    done_s        = 1'b1;
                    invalid_cpu_s = 1'b1;
                    sc_result_s   = atomic_r;
                end else begin
                    next_state_s = WR;
                end
            end
            SC_FAIL: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Registered outputs and request capture.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            c_ren_r       <= 1'b0;
            c_wen_r       <= 1'b0;
            c_addr_r      <= {ADDR_W{1'b0}};
            addr_cpu_r    <= {ADDR_W{1'b0}};
            atomic_r      <= 1'b0;
            update_r      <= 1'b0;
            invalid_cpu_r <= 1'b0;
            done_r        <= 1'b0;
            sc_result_r   <= 1'b0;
        end else begin
            c_ren_r       <= (next_state_s == RD);
            c_wen_r       <= (next_state_s == WR);
            update_r      <= update_s;
            invalid_cpu_r <= invalid_cpu_s;
            done_r        <= done_s;
            sc_result_r   <= sc_result_s;
            if (latch_s) begin
                c_addr_r   <= dmemaddr;
                addr_cpu_r <= dmemaddr;
                atomic_r   <= datomic;
            end
        end
    end

    assign c_ren       = c_ren_r;
    assign c_wen       = c_wen_r;
    assign c_addr      = c_addr_r;
    assign addr_cpu    = addr_cpu_r;
    assign addr_bus    = addr_bus_r;
    assign update      = update_r;
    assign invalid_cpu = invalid_cpu_r;
    assign invalid_bus = invalid_bus_r;
    assign done        = done_r;
    assign sc_result   = sc_result_r;

endmodule

// File: doc/llsc_ctrl.md
LLSC_CTRL -- requirements
Module: llsc_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 32; width of all address ports.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 nRST  input  1  asynchronous active-low reset.
REQ-004 dmemREN  input  1  CPU load request, held until done.
REQ-005 dmemWEN  input  1  CPU store request, held until done.
REQ-006 datomic  input  1  marks the request as LL (with REN) or SC (with WEN).
REQ-007 dmemaddr  input  ADDR_W  CPU request address.
REQ-008 c_ren  output  1  cache read request.
REQ-009 c_wen  output  1  cache write request.
REQ-010 c_addr  output  ADDR_W  cache request address, registered.
REQ-011 c_ack  input  1  cache completion, one-cycle pulse.
REQ-012 ccinv  input  1  bus snoop invalidate, one-cycle pulse.
REQ-013 ccsnoopaddr  input  ADDR_W  snoop address, valid with ccinv.
REQ-014 addr_cpu  output  ADDR_W  to link module: CPU-side address.
REQ-015 addr_bus  output  ADDR_W  to link module: snoop address.
REQ-016 update  output  1  to link module: set link, one-cycle pulse.
REQ-017 invalid_cpu  output  1  to link module: local-store invalidate pulse.
REQ-018 invalid_bus  output  1  to link module: snoop invalidate pulse.
REQ-019 write_valid  input  1  from link module: link valid and matches addr_cpu (combinational).
REQ-020 done  output  1  request complete, one-cycle pulse.
REQ-021 sc_result  output  1  SC outcome, valid with done; 0 for non-SC requests.

Function
REQ-022 FSM states SHALL be IDLE, RD, SC_CHK, WR, SC_FAIL.
REQ-023 IDLE: REN -> RD; WEN&datomic -> SC_CHK; WEN&!datomic -> WR; REN and WEN together -> REN wins.
REQ-024 On leaving IDLE, c_addr and addr_cpu SHALL latch dmemaddr and hold until return to IDLE.
REQ-025 RD: c_ren=1 until c_ack; on c_ack -> done=1, update=1 if datomic, -> IDLE.
REQ-026 SC_CHK: exactly one cycle; write_valid=1 and no kill (REQ-031) -> WR, else -> SC_FAIL.
REQ-027 WR: c_wen=1 until c_ack; on c_ack -> done=1, invalid_cpu=1, sc_result=datomic, -> IDLE.
REQ-028 SC_FAIL: done=1, sc_result=0, c_wen never asserted, -> IDLE.
REQ-029 Latency with immediate c_ack: LL/load 2 cycles, successful SC 3, failed SC 2, plain store 2 (entry edge to done).
REQ-030 Snoop path independent of FSM: ccinv at cycle N -> addr_bus=ccsnoopaddr and invalid_bus=1 at cycle N+1; back-to-back ccinv yields back-to-back pulses.
REQ-031 Kill: in SC_CHK, ccinv this cycle with ccsnoopaddr==addr_cpu, or invalid_bus this cycle with addr_bus==addr_cpu, SHALL force SC_FAIL regardless of write_valid.
REQ-032 ccinv during RD of an LL SHALL not suppress update; the link module orders the later invalidate.
REQ-033 update, invalid_cpu, invalid_bus, done SHALL never exceed one cycle; done SHALL not coincide with a new request accept.

Reset
REQ-034 nRST low SHALL immediately force IDLE and all outputs to 0, including addresses.
REQ-035 Reset during RD or WR SHALL abandon the request without done, update or invalid_cpu; a pending invalid_bus is dropped.

Configuration
REQ-036 Macro LLSC_SNOOP_EN defined: snoop path (REQ-030, REQ-031) present.
REQ-037 LLSC_SNOOP_EN undefined: ccinv/ccsnoopaddr ignored, addr_bus and invalid_bus tied 0, SC fails only on write_valid=0 (single-core build).

Verification
REQ-038 LL 0x100, c_ack next cycle -> c_ren 1 cycle, done+update together, addr_cpu=0x100.
REQ-039 LL 0x100 then SC 0x100, write_valid=1 -> c_wen asserted, done with sc_result=1, invalid_cpu pulse.
REQ-040 SC 0x100 with write_valid=0 -> done, sc_result=0 two cycles after entry, c_wen never high.
REQ-041 SC 0x100, ccinv addr 0x100 in SC_CHK cycle, write_valid=1 -> SC_FAIL, sc_result=0, invalid_bus next cycle with addr_bus=0x100; repeat with 0x200 -> success.
REQ-042 nRST low during WR (c_ack withheld) -> all outputs 0 immediately, no done; next LL after reset completes normally.
